// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides. Single-cycle ops finish in one
// cycle; MUL/MULHU/DIVU/REMU iterate one bit per cycle (shift-add and restoring divide).
module alu_mc #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       aluoperation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lt,
    output logic             gt,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     a_reg, b_reg;
    logic [1:0]           op_reg;
    logic [2*WIDTH-1:0]   p_reg;
    logic [CW-1:0]        cnt_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 zero_reg, lt_reg, gt_reg, carry_reg, overflow_reg;

    logic                 accept, long_op, last_iter;
    logic [WIDTH:0]       add_full, sub_full;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry, alu_ovf;
    logic [WIDTH:0]       mul_sum, rem_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, iter_next;
    logic [WIDTH-1:0]     fin_res;

    assign accept    = in_valid && (state_reg == IDLE);
    assign long_op   = MULDIV_EN && (aluoperation[3:2] == 2'b10);
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));
    assign add_full  = {1'b0, data1} + {1'b0, data2};
    assign sub_full  = {1'b0, data1} - {1'b0, data2};
    assign shamt     = data2[SHW-1:0];

    // Single-cycle datapath; codes without a dedicated function fall through to ADD.
    always_comb begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (data1[WIDTH-1] == data2[WIDTH-1]) && (add_full[WIDTH-1] != data1[WIDTH-1]);
        case (aluoperation)
            4'b0001: begin
                alu_res   = sub_full[WIDTH-1:0];
                alu_carry = ~sub_full[WIDTH];
                alu_ovf   = (data1[WIDTH-1] != data2[WIDTH-1]) && (sub_full[WIDTH-1] != data1[WIDTH-1]);
            end
            4'b0010: begin alu_res = data1 & data2;  alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b0011: begin alu_res = data1 | data2;  alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b0100: begin alu_res = data1 ^ data2;  alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b0101: begin alu_res = data1 << shamt; alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b0110: begin alu_res = data1 >> shamt; alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b0111: begin alu_res = WIDTH'($signed(data1) >>> shamt); alu_carry = 1'b0; alu_ovf = 1'b0; end
            4'b1110: begin
                alu_res   = {{(WIDTH-1){1'b0}}, (data1 < data2)};
                alu_carry = 1'b0;
                alu_ovf   = 1'b0;
            end
            4'b1111: begin
                alu_res   = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
                alu_carry = 1'b0;
                alu_ovf   = 1'b0;
            end
            default: ;
        endcase
    end

    // p_reg holds {high, low}: {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, b_reg} : '0);
    assign mul_next  = {mul_sum, p_reg[WIDTH-1:1]};
    assign rem_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, b_reg};
    assign div_next  = {(div_diff[WIDTH] ? rem_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        p_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    assign iter_next = op_reg[1] ? div_next : mul_next;
    assign fin_res   = op_reg[0] ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = long_op ? CALC : DONE;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            p_reg        <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            lt_reg       <= 1'b0;
            gt_reg       <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= data1;
            b_reg   <= data2;
            op_reg  <= aluoperation[1:0];
            p_reg   <= {{WIDTH{1'b0}}, data1};
            cnt_reg <= '0;
            if (!long_op) begin
                result_reg   <= alu_res;
                zero_reg     <= (alu_res == '0);
                lt_reg       <= (data1 < data2);
                gt_reg       <= (data1 > data2);
                carry_reg    <= alu_carry;
                overflow_reg <= alu_ovf;
            end
        end else if (state_reg == CALC) begin
            p_reg   <= iter_next;
            cnt_reg <= last_iter ? '0 : cnt_reg + CW'(1);
            // Outputs change only on the final iteration, so no partial value is exposed.
            if (last_iter) begin
                result_reg   <= fin_res;
                zero_reg     <= (fin_res == '0);
                lt_reg       <= (a_reg < b_reg);
                gt_reg       <= (a_reg > b_reg);
                carry_reg    <= 1'b0;
                overflow_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign lt        = lt_reg;
    assign gt        = gt_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc (WIDTH=32) against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] data1, data2, result;
    logic [3:0]   aluoperation;
    logic         zero, lt, gt, carry, overflow, busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [W-1:0] res;
        logic z, l, g, c, v;
        int   lat;
    } exp_t;

    alu_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .aluoperation(aluoperation),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .lt(lt), .gt(gt), .carry(carry), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, s;
        longint unsigned prod;
        int sh;
        logic signed [W-1:0] as_s;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sh   = int'(b % 32);
        as_s = a;
        prod = longint'(a) * longint'(b);
        e.c = 1'b0; e.v = 1'b0; e.lat = 1;
        case (op)
            4'd1: begin
                e.res = a - b; e.c = (a >= b);
                s = sa - sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = a << sh;
            4'd6:  e.res = a >> sh;
            4'd7:  e.res = as_s >>> sh;
            4'd8:  begin e.res = prod[31:0];  e.lat = W + 1; end
            4'd9:  begin e.res = prod[63:32]; e.lat = W + 1; end
            4'd10: begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.lat = W + 1; end
            4'd11: begin e.res = (b == 0) ? a : a % b;             e.lat = W + 1; end
            4'd14: e.res = (a < b) ? 1 : 0;
            4'd15: e.res = (sa < sb) ? 1 : 0;
            default: begin
                s = longint'(a) + longint'(b);
                e.res = s[31:0]; e.c = s[32];
                s = sa + sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        endcase
        e.z = (e.res == 0);
        e.l = (a < b);
        e.g = (a > b);
        return e;
    endfunction

    // Handshake one request, wait for the result, optionally stall the consumer for `hold` cycles.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        exp_t e;
        int cyc;
        bit rdy_bad, stable_bad;
        logic [W-1:0] snap;
        e = model(op, a, b);
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; aluoperation = op; data1 = a; data2 = b;
        @(negedge clk);
        in_valid = 1'b0; data1 = $urandom; data2 = $urandom;
        cyc = 1; rdy_bad = 0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_bad = 1;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, cyc, e.lat);
        check({tag, ".ready_low"}, rdy_bad, 0);
        check({tag, ".result"}, result, e.res);
        check({tag, ".flags"}, {zero, lt, gt, carry, overflow}, {e.z, e.l, e.g, e.c, e.v});
        if (hold > 0) begin
            snap = result; stable_bad = 0;
            in_valid = 1'b1; aluoperation = 4'd0; data1 = 32'd7; data2 = 32'd9;
            repeat (hold) begin
                @(negedge clk);
                if (result !== snap || !out_valid || in_ready) stable_bad = 1;
            end
            in_valid = 1'b0;
            check({tag, ".hold_stable"}, stable_bad, 0);
            check({tag, ".hold_result"}, result, e.res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, {out_valid, in_ready}, 2'b01);
        $display("[TB] %s op=%0d a=%08h b=%08h result=%08h lat=%0d", tag, op, a, b, result, cyc);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data1 = '0; data2 = '0; aluoperation = '0;
        repeat (3) @(negedge clk);
        check("reset.state", {out_valid, busy, in_ready}, 3'b001);
        check("reset.result", result, 0);
        check("reset.flags", {zero, lt, gt, carry, overflow}, 5'b10000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.in_ready", in_ready, 1);

        run_op("add_wrap",   4'd0,  32'hFFFF_FFFF, 32'd1, 0);
        run_op("sub_ovf",    4'd1,  32'h8000_0000, 32'd1, 0);
        run_op("slt",        4'd15, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu",       4'd14, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("mul",        4'd8,  32'h0001_0000, 32'h0001_0000, 0);
        run_op("mulhu",      4'd9,  32'h0001_0000, 32'h0001_0000, 0);
        run_op("divu",       4'd10, 32'd100, 32'd7, 0);
        run_op("remu",       4'd11, 32'd100, 32'd7, 0);
        run_op("divu_zero",  4'd10, 32'd5, 32'd0, 0);
        run_op("remu_zero",  4'd11, 32'd5, 32'd0, 0);
        run_op("sra",        4'd7,  32'h8000_00F0, 32'hFFFF_FF24, 0);
        run_op("sub_equal",  4'd1,  32'd42, 32'd42, 0);
        run_op("hold_done",  4'd4,  32'h1234_5678, 32'h0F0F_0F0F, 10);
        run_op("hold_mul",   4'd8,  32'hDEAD_BEEF, 32'd3, 10);

        // Reset pulsed in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1; aluoperation = 4'd10; data1 = 32'd1000; data2 = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("abort.busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort.state", {out_valid, busy, in_ready}, 3'b001);
        check("abort.result", {result, zero}, {32'd0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort.in_ready", {in_ready, out_valid}, 2'b10);
        run_op("add_after_abort", 4'd0, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(0, 40));
                2: rb = ra;
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb, (i % 7 == 0) ? 3 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
